// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multi-cycle ALU: operation codes, FSM state
// encoding and small decode helpers used by the top level and the iterative
// multiply/divide unit.
// ---------------------------------------------------------------------------
package alu_pkg;

    // Operation codes. Bit 4 set selects the iterative (RV32M) class.
    typedef enum logic [4:0] {
        OP_AND    = 5'b00000,
        OP_OR     = 5'b00001,
        OP_ADD    = 5'b00010,
        OP_XOR    = 5'b00011,
        OP_SLL    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_SUB    = 5'b00110,
        OP_SRA    = 5'b00111,
        OP_EQ     = 5'b01000,
        OP_SLT    = 5'b01100,
        OP_SLTU   = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } alu_state_e;

    // 10xxx are the iterative codes; 11xxx are reserved and complete as 0.
    function automatic logic is_iter_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

    // Divide/remainder subset of the iterative codes (10100..10111).
    function automatic logic is_div_op(input logic [4:0] op);
        return (is_iter_op(op) && (op[2] == 1'b1));
    endfunction

    // Operand A is interpreted as two's complement.
    function automatic logic is_signed_a(input logic [4:0] op);
        return ((op == OP_MULH) || (op == OP_MULHSU) ||
                (op == OP_DIV)  || (op == OP_REM));
    endfunction

    // Operand B is interpreted as two's complement (MULHSU keeps B unsigned).
    function automatic logic is_signed_b(input logic [4:0] op);
        return ((op == OP_MULH) || (op == OP_DIV) || (op == OP_REM));
    endfunction

endpackage

// File: rtl/alu_multicycle_muldiv_iter.sv
// ---------------------------------------------------------------------------
// muldiv_iter
// Iterative multiply (shift-add) and restoring divide on operand magnitudes,
// one bit per step, followed by a combinational sign fixup.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   kill         : abandon the current operation (counter cleared)
//   start        : load operands for op (takes priority over step)
//   step         : perform one iteration
//   op, a, b     : operation code and operands, sampled on start
//   last         : the current step is the final iteration
//   result       : sign-corrected result, valid once the last step is done
// ---------------------------------------------------------------------------
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  kill,
    input  logic                  start,
    input  logic                  step,
    input  logic [4:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  last,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

    // Multiply: acc = {partial product high, multiplier being shifted out}.
    // Divide:   acc = {partial remainder, dividend shifting into quotient}.
    logic [2*DATA_WIDTH-1:0] acc_r;
    logic [DATA_WIDTH-1:0]   opnd_r;     // |A| for multiply, |B| for divide
    logic [CW-1:0]           cnt_r;
    logic [2:0]              op_r;       // bit2: divide, bits1:0: variant
    logic                    neg_q_r;    // negate product / quotient
    logic                    neg_r_r;    // negate remainder

    logic                    a_neg_s;
    logic                    b_neg_s;
    logic [DATA_WIDTH-1:0]   a_mag_s;
    logic [DATA_WIDTH-1:0]   b_mag_s;
    logic [DATA_WIDTH:0]     mul_add_s;
    logic [2*DATA_WIDTH-1:0] mul_next_s;
    logic [DATA_WIDTH:0]     div_shl_s;
    logic [DATA_WIDTH:0]     div_diff_s;
    logic [2*DATA_WIDTH-1:0] div_next_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [DATA_WIDTH-1:0]   quot_s;
    logic [DATA_WIDTH-1:0]   rem_s;

    // Operand magnitudes and sign flags at start.
    always_comb begin
        a_neg_s = is_signed_a(op) & a[DATA_WIDTH-1];
        b_neg_s = is_signed_b(op) & b[DATA_WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -a;
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = -b;
        end else begin
            b_mag_s = b;
        end
    end

    // One shift-add step and one restoring-divide step.
    always_comb begin
        if (acc_r[0]) begin
            mul_add_s = {1'b0, acc_r[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, opnd_r};
        end else begin
            mul_add_s = {1'b0, acc_r[2*DATA_WIDTH-1:DATA_WIDTH]};
        end
        mul_next_s = {mul_add_s, acc_r[DATA_WIDTH-1:1]};

        // The remainder is always below the divisor, so the shifted value
        // fits in DATA_WIDTH+1 bits and a borrow means "restore".
        div_shl_s  = {acc_r[2*DATA_WIDTH-1:DATA_WIDTH], acc_r[DATA_WIDTH-1]};
        div_diff_s = div_shl_s - {1'b0, opnd_r};
        if (div_diff_s[DATA_WIDTH]) begin
            div_next_s = {div_shl_s[DATA_WIDTH-1:0], acc_r[DATA_WIDTH-2:0], 1'b0};
        end else begin
            div_next_s = {div_diff_s[DATA_WIDTH-1:0], acc_r[DATA_WIDTH-2:0], 1'b1};
        end
    end

    // Sign fixup and result selection.
    always_comb begin
        if (neg_q_r) begin
            prod_s = -acc_r;
            quot_s = -acc_r[DATA_WIDTH-1:0];
        end else begin
            prod_s = acc_r;
            quot_s = acc_r[DATA_WIDTH-1:0];
        end
        if (neg_r_r) begin
            rem_s = -acc_r[2*DATA_WIDTH-1:DATA_WIDTH];
        end else begin
            rem_s = acc_r[2*DATA_WIDTH-1:DATA_WIDTH];
        end
        case (op_r)
            3'b000:  result = prod_s[DATA_WIDTH-1:0];
            3'b001,
            3'b010,
            3'b011:  result = prod_s[2*DATA_WIDTH-1:DATA_WIDTH];
            3'b100,
            3'b101:  result = quot_s;
            3'b110,
            3'b111:  result = rem_s;
            default: result = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign last = step & (cnt_r == LAST_CNT);

    // Operand load, iteration and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r   <= {(2*DATA_WIDTH){1'b0}};
            opnd_r  <= {DATA_WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            op_r    <= 3'b000;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (kill) begin
            cnt_r   <= {CW{1'b0}};
        end else if (start) begin
            op_r    <= op[2:0];
            cnt_r   <= {CW{1'b0}};
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            if (op[2]) begin
                acc_r  <= {{DATA_WIDTH{1'b0}}, a_mag_s};
                opnd_r <= b_mag_s;
            end else begin
                acc_r  <= {{DATA_WIDTH{1'b0}}, b_mag_s};
                opnd_r <= a_mag_s;
            end
        end else if (step) begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (op_r[2]) begin
                acc_r <= div_next_s;
            end else begin
                acc_r <= mul_next_s;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// ---------------------------------------------------------------------------
// alu_multicycle
// Execute-stage integer ALU with RV32I logic/compare/shift ops completed in
// one cycle and RV32M multiply/divide ops completed by an iterative unit.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake
//   flush               : kill the in-flight op and refuse this cycle's input
//   Operation, SrcA/B   : operation select and operands
//   out_valid           : one-cycle pulse, ALUResult valid
//   ALUResult           : registered result, held until the next completion
//   busy                : iterative operation in progress
// ---------------------------------------------------------------------------
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     flush,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     busy
);

    localparam int SW = $clog2(DATA_WIDTH);
    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_DIV  = ST_DIV;
    localparam logic [1:0] S_FIX  = ST_FIX;
    localparam logic [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]            state_r;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] result_r;

    logic [4:0]            op_s;
    logic [SW-1:0]         shamt_s;
    logic                  accept_s;
    logic [DATA_WIDTH-1:0] single_s;
    logic                  special_s;
    logic [DATA_WIDTH-1:0] special_res_s;
    logic                  iter_start_s;
    logic                  iter_step_s;
    logic                  iter_last_s;
    logic [DATA_WIDTH-1:0] iter_res_s;

    assign op_s      = Operation[4:0];
    assign shamt_s   = SrcB[SW-1:0];
    assign in_ready  = (state_r == S_IDLE) & ~reset;
    assign accept_s  = in_valid & in_ready & ~flush;
    assign out_valid = out_valid_r;
    assign ALUResult = result_r;
    assign busy      = (state_r != S_IDLE);

    // Single-cycle datapath; unlisted codes (including 11xxx) give zero.
    always_comb begin
        case (op_s)
            OP_AND:  single_s = SrcA & SrcB;
            OP_OR:   single_s = SrcA | SrcB;
            OP_XOR:  single_s = SrcA ^ SrcB;
            OP_ADD:  single_s = SrcA + SrcB;
            OP_SUB:  single_s = SrcA - SrcB;
            OP_EQ:   single_s = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
            OP_SLT:  single_s = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
            OP_SLTU: single_s = {{(DATA_WIDTH-1){1'b0}}, (SrcA < SrcB)};
            OP_SLL:  single_s = SrcA << shamt_s;
            OP_SRL:  single_s = SrcA >> shamt_s;
            OP_SRA:  single_s = $signed(SrcA) >>> shamt_s;
            default: single_s = {DATA_WIDTH{1'b0}};
        endcase
    end

    // Divide-by-zero and MIN/-1 bypass the iterative unit entirely.
    always_comb begin
        special_s     = 1'b0;
        special_res_s = {DATA_WIDTH{1'b0}};
        if (is_div_op(op_s) && (SrcB == {DATA_WIDTH{1'b0}})) begin
            special_s = 1'b1;
            if (op_s[1]) begin
                special_res_s = SrcA;
            end else begin
                special_res_s = {DATA_WIDTH{1'b1}};
            end
        end else if (is_div_op(op_s) && is_signed_a(op_s) &&
                     (SrcA == MIN_VAL) && (SrcB == {DATA_WIDTH{1'b1}})) begin
            special_s = 1'b1;
            if (op_s[1]) begin
                special_res_s = {DATA_WIDTH{1'b0}};
            end else begin
                special_res_s = MIN_VAL;
            end
        end else begin
            special_s     = 1'b0;
            special_res_s = {DATA_WIDTH{1'b0}};
        end
    end

    assign iter_start_s = accept_s & is_iter_op(op_s) & ~special_s;
    assign iter_step_s  = (state_r == S_MUL) | (state_r == S_DIV);

    muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_muldiv_iter (
        .clk    (clk),
        .reset  (reset),
        .kill   (flush),
        .start  (iter_start_s),
        .step   (iter_step_s),
        .op     (op_s),
        .a      (SrcA),
        .b      (SrcB),
        .last   (iter_last_s),
        .result (iter_res_s)
    );

    // Control FSM and result register; reset beats flush beats accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            result_r    <= {DATA_WIDTH{1'b0}};
        end else if (flush) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    out_valid_r <= 1'b0;
                    if (accept_s) begin
                        if (!is_iter_op(op_s)) begin
                            result_r    <= single_s;
                            out_valid_r <= 1'b1;
                        end else if (special_s) begin
                            result_r    <= special_res_s;
                            out_valid_r <= 1'b1;
                        end else if (is_div_op(op_s)) begin
                            state_r <= S_DIV;
                        end else begin
                            state_r <= S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    out_valid_r <= 1'b0;
                    if (iter_last_s) begin
                        state_r <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_r    <= iter_res_s;
                    out_valid_r <= 1'b1;
                    state_r     <= S_IDLE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
